// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen
// Instruction-fetch front end. Owns the fetch PC, issues one request at a
// time on the SRAM-like instruction bus, buffers the returned instruction
// for the IF/ID register and applies exception/branch redirects.
//
// Ports:
//   clk, reset          clock (rising edge) and async active-high reset
//   exc_valid, exc_pc   exception/eret redirect (higher priority)
//   br_valid, br_pc     branch/jump redirect
//   inst_req, inst_addr fetch request and its address
//   inst_addr_ok        request accepted this cycle
//   inst_data_ok        instruction data returned this cycle
//   inst_rdata          returned instruction word
//   out_valid, out_ready handshake towards decode
//   out_pc, out_inst    presented PC / instruction (0 on misaligned fetch)
//   out_adel            misaligned fetch address flag
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_DATA,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_adel_q, out_adel_d;

  logic        redirect;
  logic [31:0] redir_pc;
  logic        pc_misaligned;

  // Exception wins over branch when both pulse together.
  assign redirect      = exc_valid | br_valid;
  assign redir_pc      = exc_valid ? exc_pc : br_pc;
  assign pc_misaligned = (pc_q[1:0] != 2'b00);

  // Request is decoded from registered state and pc only, so redirect
  // inputs never reach the bus combinationally.
  assign inst_req  = (state_q == S_REQ) && !pc_misaligned;
  assign inst_addr = pc_q;

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign out_adel  = out_adel_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    out_adel_d = out_adel_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
        if (redirect) pc_d = redir_pc;
      end

      S_REQ: begin
        if (pc_misaligned) begin
          // A redirect still wins; otherwise report the bad address
          // without ever touching the bus.
          if (redirect) begin
            pc_d = redir_pc;
          end else begin
            state_d    = S_HOLD;
            out_adel_d = 1'b1;
            out_pc_d   = pc_q;
            out_inst_d = '0;
          end
        end else if (inst_addr_ok) begin
          req_pc_d = pc_q;
          state_d  = S_DATA;
          // The accepted request cannot be recalled, so its data is
          // dropped when it arrives.
          if (redirect) begin
            discard_d = 1'b1;
            pc_d      = redir_pc;
          end else begin
            pc_d = pc_q + 32'(PC_STEP);
          end
        end else if (redirect) begin
          pc_d = redir_pc;
        end
      end

      S_DATA: begin
        if (inst_data_ok) begin
          discard_d = 1'b0;
          if (discard_q || redirect) begin
            state_d = S_REQ;
            if (redirect) pc_d = redir_pc;
          end else begin
            state_d    = S_HOLD;
            out_pc_d   = req_pc_q;
            out_inst_d = inst_rdata;
            out_adel_d = 1'b0;
          end
        end else if (redirect) begin
          discard_d = 1'b1;
          pc_d      = redir_pc;
        end
      end

      S_HOLD: begin
        // A misaligned-fetch entry only leaves through a redirect.
        if (redirect) begin
          state_d    = S_REQ;
          pc_d       = redir_pc;
          out_adel_d = 1'b0;
        end else if (out_ready && !out_adel_q) begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_BOOT;
    endcase

    out_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      discard_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      discard_q   <= discard_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_adel_q  <= out_adel_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen
// Directed scenarios followed by a randomized run of the fetch front end,
// every cycle compared against a transaction-level model of the fetch unit.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid, br_valid;
  logic [31:0] exc_pc, br_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        out_adel;

  int checks = 0;
  int errors = 0;

  fetch_pc_gen dut (
    .clk          (clk),
    .reset        (reset),
    .exc_valid    (exc_valid),
    .exc_pc       (exc_pc),
    .br_valid     (br_valid),
    .br_pc        (br_pc),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_adel     (out_adel)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model, kept as "what the fetch unit is doing" flags rather
  // than a state machine: started, waiting on data, response to be dropped,
  // instruction buffered for decode.
  bit          m_started, m_inflight, m_squash, m_have, m_adel;
  logic [31:0] m_pc, m_req_pc, m_out_pc, m_out_inst;

  function automatic bit mReq();
    return m_started && !m_inflight && !m_have && (m_pc[1:0] == 2'b00);
  endfunction

  task automatic modelReset();
    m_started  = 0;
    m_inflight = 0;
    m_squash   = 0;
    m_have     = 0;
    m_adel     = 0;
    m_pc       = 32'hBFC0_0000;
    m_req_pc   = 32'h0;
    m_out_pc   = 32'h0;
    m_out_inst = 32'h0;
  endtask

  task automatic modelStep();
    bit          redir;
    logic [31:0] tgt;
    redir = exc_valid || br_valid;
    tgt   = exc_valid ? exc_pc : br_pc;
    if (!m_started) begin
      m_started = 1;
      if (redir) m_pc = tgt;
    end else if (m_have) begin
      if (redir) begin
        m_have = 0;
        m_adel = 0;
        m_pc   = tgt;
      end else if (out_ready && !m_adel) begin
        m_have = 0;
      end
    end else if (m_inflight) begin
      if (inst_data_ok) begin
        m_inflight = 0;
        if (m_squash || redir) begin
          m_squash = 0;
          if (redir) m_pc = tgt;
        end else begin
          m_have     = 1;
          m_adel     = 0;
          m_out_pc   = m_req_pc;
          m_out_inst = inst_rdata;
        end
      end else if (redir) begin
        m_squash = 1;
        m_pc     = tgt;
      end
    end else if (m_pc[1:0] != 2'b00) begin
      if (redir) begin
        m_pc = tgt;
      end else begin
        m_have     = 1;
        m_adel     = 1;
        m_out_pc   = m_pc;
        m_out_inst = 32'h0;
      end
    end else if (inst_addr_ok) begin
      m_inflight = 1;
      m_req_pc   = m_pc;
      if (redir) begin
        m_squash = 1;
        m_pc     = tgt;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end else if (redir) begin
      m_pc = tgt;
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [31:0] ep,
                               input logic bv, input logic [31:0] bp,
                               input logic aok, input logic dok,
                               input logic [31:0] rdata, input logic rdy);
    exc_valid    = ev;
    exc_pc       = ep;
    br_valid     = bv;
    br_pc        = bp;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
    out_ready    = rdy;
  endtask

  // Compares every DUT output the model currently defines.
  task automatic checkOutput();
    check1("inst_req", inst_req, mReq());
    if (mReq()) check32("inst_addr", inst_addr, m_pc);
    check1("out_valid", out_valid, m_have);
    if (m_have) begin
      check32("out_pc", out_pc, m_out_pc);
      check32("out_inst", out_inst, m_out_inst);
      check1("out_adel", out_adel, m_adel);
    end
  endtask

  task automatic checkReset(input string tag);
    check1({tag, "_req"}, inst_req, 1'b0);
    check32({tag, "_addr"}, inst_addr, 32'hBFC0_0000);
    check1({tag, "_valid"}, out_valid, 1'b0);
    check32({tag, "_pc"}, out_pc, 32'h0);
    check32({tag, "_inst"}, out_inst, 32'h0);
    check1({tag, "_adel"}, out_adel, 1'b0);
  endtask

  // One clock: the model advances on the rising edge using the inputs
  // applied beforehand, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) modelReset();
    else       modelStep();
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = $urandom;
    t[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
    return t;
  endfunction

  logic [31:0] acc_q[$];
  logic [31:0] s_pc, s_inst;

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #1;
    checkReset("reset");
    cycle();
    cycle();
    reset = 1'b0;

    // Back-to-back fetch with an always-ready bus and decode.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(0, 0, 0, 0, mReq(), m_inflight, 32'h1000_0000 + k, 1);
      if (mReq()) acc_q.push_back(inst_addr);
      cycle();
    end
    check32("seq_count", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() >= 3) begin
      check32("seq0", acc_q[0], 32'hBFC0_0000);
      check32("seq1", acc_q[1], 32'hBFC0_0004);
      check32("seq2", acc_q[2], 32'hBFC0_0008);
    end

    // Decode stall while an instruction is held.
    for (int k = 0; k < 10 && !m_have; k++) begin
      applyStimulus(0, 0, 0, 0, mReq(), m_inflight, 32'hCAFE_0000 + k, 0);
      cycle();
    end
    check1("stall_reached", out_valid, 1'b1);
    s_pc   = m_out_pc;
    s_inst = m_out_inst;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check1("stall_valid", out_valid, 1'b1);
      check32("stall_pc", out_pc, s_pc);
      check32("stall_inst", out_inst, s_inst);
      check1("stall_noreq", inst_req, 1'b0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    check1("release_req", inst_req, 1'b1);
    check32("release_addr", inst_addr, s_pc + 32'd4);

    // Branch while waiting for data: the late response is discarded.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 1, 32'h8000_1000, 0, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    cycle();
    check1("br_data_req", inst_req, 1'b1);
    check32("br_data_addr", inst_addr, 32'h8000_1000);
    check1("br_data_novalid", out_valid, 1'b0);

    // Exception and branch together: exception wins.
    applyStimulus(1, 32'hBFC0_0380, 1, 32'h8000_2000, 0, 0, 0, 1);
    cycle();
    check1("prio_req", inst_req, 1'b1);
    check32("prio_addr", inst_addr, 32'hBFC0_0380);

    // Misaligned branch target: address error held until an exception.
    applyStimulus(0, 0, 1, 32'h8000_0002, 0, 0, 0, 1);
    cycle();
    check1("adel_noreq", inst_req, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check1("adel_valid", out_valid, 1'b1);
      check1("adel_flag", out_adel, 1'b1);
      check32("adel_pc", out_pc, 32'h8000_0002);
      check32("adel_inst", out_inst, 32'h0);
      check1("adel_noreq2", inst_req, 1'b0);
    end

    // Exception to the last word of the address space, then wrap.
    applyStimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1);
    cycle();
    check1("flush_novalid", out_valid, 1'b0);
    check32("wrap_addr0", inst_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678, 1);
    cycle();
    check32("wrap_outpc", out_pc, 32'hFFFF_FFFC);
    check32("wrap_outinst", out_inst, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    cycle();
    check1("wrap_req", inst_req, 1'b1);
    check32("wrap_addr", inst_addr, 32'h0000_0000);

    // Reset in the middle of a transaction clears outputs immediately.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h5555_AAAA, 1);
    #2;
    reset = 1'b1;
    #1;
    checkReset("midreset");
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    check1("boot_noreq", inst_req, 1'b0);
    cycle();
    check1("boot_req", inst_req, 1'b1);
    check32("boot_addr", inst_addr, 32'hBFC0_0000);

    // Randomized bus timing, decode stalls and redirects.
    for (int k = 0; k < 3000; k++) begin
      int  r;
      logic ev, bv, aok, dok, rdy;
      r   = $urandom_range(0, 99);
      ev  = (r < 4);
      bv  = (r >= 2) && (r < 9);
      aok = mReq() && ($urandom_range(0, 99) < 60);
      dok = m_inflight && ($urandom_range(0, 99) < 50);
      rdy = ($urandom_range(0, 99) < 70);
      applyStimulus(ev, randTarget(), bv, randTarget(), aok, dok, $urandom, rdy);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
